// File: rtl/s_sub_pkg.sv
`default_nettype none
// ==================================================================
// s_sub_pkg : shared types and constants for the serial subtractor
// Revision  : 1.0
// ==================================================================
package s_sub_pkg;

   localparam int S_SUB_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/s_sub_fs_cell.sv
`default_nettype none
// ==================================================================
// fs_cell : one-bit full subtractor, d = x - y - bin
// Revision: 1.0
// ==================================================================
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule
`default_nettype wire

// File: rtl/s_sub.sv
`default_nettype none
// ==================================================================
// s_sub : bit-serial subtractor, a = {c,s} - b, LSB first, start/busy/done
// Optional streaming outputs d_bit/d_vld when S_SUB_STREAM_EN is defined.
// Revision: 1.0
// ==================================================================
module s_sub
   import s_sub_pkg::*;
#(
   parameter int W = S_SUB_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] s,
   input  logic         c,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] a,
   output logic         err
`ifdef S_SUB_STREAM_EN
   ,
   output logic         d_bit,
   output logic         d_vld
`endif
);

   localparam int CW = $clog2(W + 1);

   state_t          state;
   state_t          state_nx;
   logic [W-1:0]    m_sr;
   logic [W-1:0]    b_sr;
   logic [W-1:0]    a_sr;
   logic            c_q;
   logic            borrow;
   logic [CW-1:0]   count;
   logic            cell_d;
   logic            cell_bout;
   logic            last;

   fs_cell u_fs_cell (
      .x    (m_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last = (count == CW'(W - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // a/err are written on the final SHIFT edge so they are already valid in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         m_sr   <= '0;
         b_sr   <= '0;
         a_sr   <= '0;
         c_q    <= 1'b0;
         borrow <= 1'b0;
         count  <= '0;
         a      <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  m_sr   <= s;
                  b_sr   <= b;
                  c_q    <= c;
                  borrow <= 1'b0;
                  count  <= '0;
               end
            end
            SHIFT: begin
               borrow <= cell_bout;
               m_sr   <= m_sr >> 1;
               b_sr   <= b_sr >> 1;
               a_sr   <= {cell_d, a_sr[W-1:1]};
               count  <= count + 1'b1;
               if (last) begin
                  a   <= {cell_d, a_sr[W-1:1]};
                  err <= c_q ^ cell_bout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

`ifdef S_SUB_STREAM_EN
   assign d_vld = (state == SHIFT);
   assign d_bit = (state == SHIFT) ? cell_d : 1'b0;
`endif

endmodule
`default_nettype wire
